// File: rtl/deinterleave_buffer_if.sv
// Write-beat and read-beat handshake bundle for the deinterleave buffer.
// The slave modport is the buffer's view; the master modport is the producer/consumer view.
interface deinterleave_buffer_if #(
    parameter int p     = 32,
    parameter int z     = 8,
    parameter int width = 16
);
    localparam int AW = $clog2(p);
    localparam int BW = $clog2(p / z);

    logic                 in_valid;
    logic                 in_ready;
    logic [AW*z-1:0]      memory_index_package;
    logic [width*z-1:0]   in_data_package;
    logic                 out_valid;
    logic                 out_ready;
    logic [width*z-1:0]   out_data_package;
    logic [BW-1:0]        out_beat;
    logic                 collision;

    modport slave (
        input  in_valid, memory_index_package, in_data_package, out_ready,
        output in_ready, out_valid, out_data_package, out_beat, collision
    );

    modport master (
        output in_valid, memory_index_package, in_data_package, out_ready,
        input  in_ready, out_valid, out_data_package, out_beat, collision
    );
endinterface

// File: rtl/deinterleave_buffer.sv
// Ping-pong scatter buffer: z lanes per beat write to arbitrary addresses of one bank,
// while the other bank is read out in natural order, z words per beat.
module deinterleave_buffer #(
    parameter int p     = 32,
    parameter int z     = 8,
    parameter int width = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    deinterleave_buffer_if.slave     bus
);
    localparam int B  = p / z;
    localparam int AW = $clog2(p);
    localparam int BW = $clog2(B);
    localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);

    logic                 wsel_q, wsel_d;
    logic                 rsel_q, rsel_d;
    logic [BW-1:0]        wcnt_q, wcnt_d;
    logic [BW-1:0]        rcnt_q, rcnt_d;
    logic [1:0]           full_q, full_d;
    logic [p-1:0]         mask_q [2];
    logic [p-1:0]         mask_d [2];
    logic                 collision_q, collision_d;
    logic [width-1:0]     bank_q [2][p];
    logic [width-1:0]     bank_d [2][p];

    logic                 wr_accept;
    logic                 rd_accept;
    logic [AW-1:0]        wr_addr;
    logic [p-1:0]         seen;
    logic                 hit;

    assign wr_accept = bus.in_valid && !full_q[wsel_q];
    assign rd_accept = full_q[rsel_q] && bus.out_ready;

    always_comb begin
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        full_d      = full_q;
        mask_d      = mask_q;
        collision_d = collision_q;
        bank_d      = bank_q;
        wr_addr     = '0;
        seen        = mask_q[wsel_q];
        hit         = 1'b0;

        // Lanes are walked in ascending order so the highest lane wins a shared address,
        // and 'seen' catches both earlier-beat and same-beat repeats.
        for (int i = 0; i < z; i++) begin
            wr_addr = bus.memory_index_package[i*AW +: AW];
            if (seen[wr_addr]) begin
                hit = 1'b1;
            end
            seen[wr_addr] = 1'b1;
            if (wr_accept) begin
                bank_d[wsel_q][wr_addr] = bus.in_data_package[i*width +: width];
            end
        end

        if (wr_accept) begin
            mask_d[wsel_q] = seen;
            if (hit) begin
                collision_d = 1'b1;
            end
            if (wcnt_q == LAST_BEAT) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
                wcnt_d         = '0;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        // A read only ever targets the full bank, never the one being written.
        if (rd_accept) begin
            if (rcnt_q == LAST_BEAT) begin
                full_d[rsel_q] = 1'b0;
                mask_d[rsel_q] = '0;
                rsel_d         = ~rsel_q;
                rcnt_d         = '0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            full_q      <= '0;
            mask_q[0]   <= '0;
            mask_q[1]   <= '0;
            collision_q <= 1'b0;
        end else begin
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            full_q      <= full_d;
            mask_q      <= mask_d;
            collision_q <= collision_d;
        end
    end

    // Word storage is not reset; the masks decide what is visible.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign bus.in_ready  = !full_q[wsel_q];
    assign bus.out_valid = full_q[rsel_q];
    assign bus.out_beat  = rcnt_q;
    assign bus.collision = collision_q;

    generate
        for (genvar gi = 0; gi < z; gi++) begin : g_out_lane
            logic [AW-1:0] ridx;
            assign ridx = AW'(int'(rcnt_q) * z + gi);
            assign bus.out_data_package[gi*width +: width] =
                mask_q[rsel_q][ridx] ? bank_q[rsel_q][ridx] : '0;
        end
    endgenerate
endmodule

// File: tb/tb_deinterleave_buffer.sv
// Directed bench for deinterleave_buffer (p=32, z=8, width=16) with hand-built frames.
module tb_deinterleave_buffer;
    localparam int P  = 32;
    localparam int Z  = 8;
    localparam int W  = 16;
    localparam int B  = P / Z;

    typedef logic [P*W-1:0] frame_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    deinterleave_buffer_if #(.p(P), .z(Z), .width(W)) bus ();

    deinterleave_buffer #(.p(P), .z(Z), .width(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] gen(input int f, input int k);
        if (f == 1) return 16'(100 + k);
        return 16'(f * 97 + k * 13 + 5);
    endfunction

    function automatic frame_t gen_frame(input int f);
        frame_t r;
        for (int k = 0; k < P; k++) r[k*W +: W] = gen(f, k);
        return r;
    endfunction

    // Beat c, lane i targets 4*i + ((c+i+f)%4): every frame covers all 32 words exactly once.
    task automatic build_beat(input int f, input int c, output logic [5*Z-1:0] a, output logic [W*Z-1:0] d);
        int addr;
        for (int i = 0; i < Z; i++) begin
            addr = 4 * i + ((c + i + f) % 4);
            a[i*5 +: 5] = 5'(addr);
            d[i*W +: W] = gen(f, addr);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic write_beat(input logic [5*Z-1:0] a, input logic [W*Z-1:0] d);
        int guard;
        guard = 0;
        bus.in_valid             = 1'b1;
        bus.memory_index_package = a;
        bus.in_data_package      = d;
        @(negedge clk);
        while (!bus.in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check_value("write_timeout", 256'(guard), 256'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        $display("write beat: addr=%h data=%h", a, d);
    endtask

    task automatic write_frame(input int f);
        logic [5*Z-1:0] a;
        logic [W*Z-1:0] d;
        for (int c = 0; c < B; c++) begin
            build_beat(f, c, a, d);
            write_beat(a, d);
        end
    endtask

    task automatic read_beats(input frame_t ew, input bit rnd);
        int b;
        int guard;
        bit stalled;
        logic [W*Z-1:0] held;
        logic [1:0] held_beat;
        b = 0; guard = 0; stalled = 0; held = '0; held_beat = '0;
        while (b < B && guard < 500) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stalled) begin
                check_value("hold_beat", 256'(bus.out_beat), 256'(held_beat));
                check_value("hold_data", 256'(bus.out_data_package), 256'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                check_value("out_beat", 256'(bus.out_beat), 256'(b));
                check_value("out_data", 256'(bus.out_data_package), 256'(ew[b*W*Z +: W*Z]));
                $display("read beat %0d: data=%h", b, bus.out_data_package);
                b++;
                stalled = 0;
            end else begin
                stalled   = bus.out_valid;
                held      = bus.out_data_package;
                held_beat = bus.out_beat;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        bus.out_ready = 1'b0;
        if (guard >= 500) check_value("read_timeout", 256'(b), 256'(B));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_in_ready"},  256'(bus.in_ready),  256'(1));
        check_value({tag, "_out_valid"}, 256'(bus.out_valid), 256'(0));
        check_value({tag, "_out_beat"},  256'(bus.out_beat),  256'(0));
        check_value({tag, "_out_data"},  256'(bus.out_data_package), 256'(0));
        check_value({tag, "_collision"}, 256'(bus.collision), 256'(0));
    endtask

    initial begin
        logic [5*Z-1:0] a;
        logic [W*Z-1:0] d;
        frame_t ef;
        int dup, skip;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.memory_index_package = '0;
        bus.in_data_package = '0;
        #1 reset = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Natural frame 100..131, streaming readout.
        bus.out_ready = 1'b1;
        for (int c = 0; c < B; c++) begin
            if (c == B - 1) check_value("t1_valid_before", 256'(bus.out_valid), 256'(0));
            build_beat(1, c, a, d);
            write_beat(a, d);
        end
        check_value("t1_valid_after", 256'(bus.out_valid), 256'(1));
        read_beats(gen_frame(1), 0);
        check_value("t1_collision", 256'(bus.collision), 256'(0));

        // Both banks fill, writer stalls, then drains.
        bus.out_ready = 1'b0;
        write_frame(2);
        write_frame(3);
        build_beat(4, 0, a, d);
        bus.in_valid = 1'b1;
        bus.memory_index_package = a;
        bus.in_data_package = d;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_value("t2_in_ready_stall", 256'(bus.in_ready), 256'(0));
            check_value("t2_out_valid", 256'(bus.out_valid), 256'(1));
            @(posedge clk);
            #1;
        end
        fork
            write_frame(4);
            begin
                read_beats(gen_frame(2), 0);
                read_beats(gen_frame(3), 0);
                read_beats(gen_frame(4), 0);
            end
        join

        // Beat 1 lane 0 repeats beat 0 lane 0's address.
        check_value("t3_collision_pre", 256'(bus.collision), 256'(0));
        ef = gen_frame(5);
        build_beat(5, 0, a, d);
        dup = int'(a[4:0]);
        write_beat(a, d);
        check_value("t3_collision_beat0", 256'(bus.collision), 256'(0));
        build_beat(5, 1, a, d);
        skip = int'(a[4:0]);
        a[4:0] = 5'(dup);
        d[15:0] = 16'h1234;
        write_beat(a, d);
        check_value("t3_collision_beat1", 256'(bus.collision), 256'(1));
        for (int c = 2; c < B; c++) begin
            build_beat(5, c, a, d);
            write_beat(a, d);
        end
        ef[dup*W +: W] = 16'h1234;
        ef[skip*W +: W] = 16'h0000;
        read_beats(ef, 0);
        write_frame(6);
        read_beats(gen_frame(6), 0);
        check_value("t3_collision_sticky", 256'(bus.collision), 256'(1));

        // Lanes 2 and 5 share address 7; lane 7 moved to 2 so word 5 stays empty.
        reset = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_value("t4_collision_pre", 256'(bus.collision), 256'(0));
        for (int c = 0; c < B; c++) begin
            for (int i = 0; i < Z; i++) begin
                a[i*5 +: 5] = 5'(c * 8 + i);
                d[i*W +: W] = gen(7, c * 8 + i);
            end
            if (c == 0) begin
                a[2*5 +: 5] = 5'd7; d[2*W +: W] = 16'hAAAA;
                a[5*5 +: 5] = 5'd7; d[5*W +: W] = 16'hBBBB;
                a[7*5 +: 5] = 5'd2; d[7*W +: W] = gen(7, 2);
            end
            write_beat(a, d);
            if (c == 0) check_value("t4_collision", 256'(bus.collision), 256'(1));
        end
        ef = gen_frame(7);
        ef[7*W +: W] = 16'hBBBB;
        ef[5*W +: W] = 16'h0000;
        read_beats(ef, 0);

        // Async reset mid-read and mid-write.
        write_frame(8);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check_value("t5_out_beat_pre", 256'(bus.out_beat), 256'(1));
        build_beat(9, 0, a, d);
        write_beat(a, d);
        build_beat(9, 1, a, d);
        write_beat(a, d);
        check_value("t5_out_valid_pre", 256'(bus.out_valid), 256'(1));
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        @(posedge clk);
        #1 reset = 1'b0;
        write_frame(10);
        read_beats(gen_frame(10), 0);

        // Continuous writes against a randomly stalling reader.
        fork
            for (int f = 11; f < 16; f++) write_frame(f);
            for (int f = 11; f < 16; f++) read_beats(gen_frame(f), 1);
        join
        check_value("t6_out_valid_end", 256'(bus.out_valid), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
